// File: rtl/memory_stage_if.sv
// Shared M-stage pipeline bundle types and the valid/ready data-bus interface
// between the memory stage (master) and the data memory (slave).
package memory_stage_pkg;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] write_data;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic [31:0] pc_branch;
        logic        zero;
        logic [31:0] alu_result;
        logic [4:0]  write_reg;
    } e_m_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  write_reg;
    } m_w_reg_t;

endpackage

interface memory_stage_if;
    logic        dreq_valid;
    logic        dreq_write;
    logic [31:0] dreq_addr;
    logic [31:0] dreq_wdata;
    logic [3:0]  dreq_strobe;
    logic        dresp_ready;
    logic [31:0] dresp_data;

    modport master (
        output dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strobe,
        input  dresp_ready, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_write, dreq_addr, dreq_wdata, dreq_strobe,
        output dresp_ready, dresp_data
    );
endinterface

// File: rtl/memory_stage.sv
// MIPS memory stage: M pipeline register, word load/store over a valid/ready
// bus with a bounded wait, branch resolution and the M->W register.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no access waiting; counter cleared
//   S_BUSY | access issued, waiting for dresp_ready; counter running
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int WAIT_LIMIT = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  e_m_reg_t      e_m_reg,
    memory_stage_if.master dbus,
    output logic          mem_stall,
    output logic          pcsrc,
    output logic [31:0]   pc_branch,
    output logic [31:0]   aluoutM,
    output logic [4:0]    write_regM,
    output logic          reg_writeM,
    output m_w_reg_t      m_w_reg,
    output logic          misalign,
    output logic          bus_err,
    output logic          bus_err_sticky
);

    localparam int              CNT_W   = $clog2(WAIT_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WAIT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    e_m_reg_t         m_q, m_d;
    m_w_reg_t         w_q, w_d;
    logic             sticky_q, sticky_d;

    logic mem_op, aligned, at_limit, abort, req, done, stall;
    logic [31:0] unused_pc_plus_4;

    assign unused_pc_plus_4 = m_q.pc_plus_4;

    always_comb begin
        mem_op   = m_q.mem_to_reg | m_q.mem_write;
        aligned  = (m_q.alu_result[1:0] == 2'b00);
        at_limit = (state_q == S_BUSY) && (cnt_q >= CNT_LIM);
        // Ready in the limit cycle still completes; only a silent bus aborts.
        abort    = mem_op & aligned & at_limit & ~dbus.dresp_ready;
        req      = mem_op & aligned & ~abort;
        done     = req & dbus.dresp_ready;
        stall    = req & ~dbus.dresp_ready;

        state_d  = stall ? S_BUSY : S_IDLE;
        cnt_d    = '0;
        if (stall) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        end

        m_d      = stall ? m_q : e_m_reg;
        sticky_d = sticky_q | abort;

        w_d = '0;
        if (!stall) begin
            w_d.reg_write  = m_q.reg_write & ~(mem_op & ~aligned) & ~abort;
            w_d.mem_to_reg = m_q.mem_to_reg;
            w_d.alu_result = m_q.alu_result;
            w_d.read_data  = (done && !m_q.mem_write) ? dbus.dresp_data : 32'h0;
            w_d.write_reg  = m_q.write_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            w_q      <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            w_q      <= w_d;
            sticky_q <= sticky_d;
        end
    end

    assign dbus.dreq_valid  = req;
    assign dbus.dreq_write  = m_q.mem_write;
    assign dbus.dreq_addr   = m_q.alu_result;
    assign dbus.dreq_wdata  = m_q.write_data;
    assign dbus.dreq_strobe = m_q.mem_write ? 4'b1111 : 4'b0000;

    assign mem_stall      = stall;
    assign pcsrc          = m_q.branch & m_q.zero;
    assign pc_branch      = m_q.pc_branch;
    assign aluoutM        = m_q.alu_result;
    assign write_regM     = m_q.write_reg;
    assign reg_writeM     = m_q.reg_write;
    assign m_w_reg        = w_q;
    assign misalign       = mem_op & ~aligned;
    assign bus_err        = abort;
    assign bus_err_sticky = sticky_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (WAIT_LIMIT=4): a vector table of single-entry
// operations plus hand sequences for wait states, timeout and mid-access reset.
module tb_memory_stage;
    import memory_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  strobe;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        pcsrc;
        logic [31:0] pcb;
        logic [31:0] aluout;
        logic [4:0]  wreg;
        logic        rwm;
        logic        mis;
        logic        berr;
        logic        sticky;
    } obs_t;

    typedef struct {
        e_m_reg_t    em;
        logic        ready;
        logic [31:0] rdata;
        obs_t        exp_o;
        m_w_reg_t    exp_w;
    } vec_t;

    logic clk, resetn;
    e_m_reg_t e_m_reg;
    logic mem_stall, pcsrc, reg_writeM, misalign, bus_err, bus_err_sticky;
    logic [31:0] pc_branch, aluoutM;
    logic [4:0] write_regM;
    m_w_reg_t m_w_reg;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[8];

    memory_stage_if dbus ();

    memory_stage #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn), .e_m_reg(e_m_reg), .dbus(dbus),
        .mem_stall(mem_stall), .pcsrc(pcsrc), .pc_branch(pc_branch),
        .aluoutM(aluoutM), .write_regM(write_regM), .reg_writeM(reg_writeM),
        .m_w_reg(m_w_reg), .misalign(misalign), .bus_err(bus_err),
        .bus_err_sticky(bus_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic e_m_reg_t em(input logic rw, m2r, mw, br, z,
                                    input logic [31:0] pcb, alu, wd,
                                    input logic [4:0] wr);
        em = '{pc_plus_4: alu ^ 32'h0000_1004, write_data: wd, reg_write: rw,
               mem_to_reg: m2r, mem_write: mw, branch: br, pc_branch: pcb,
               zero: z, alu_result: alu, write_reg: wr};
    endfunction

    function automatic obs_t ob(input logic v, w, input logic [3:0] s,
                                input logic [31:0] a, wd, input logic st, pc,
                                input logic [31:0] pcb, alu, input logic [4:0] wr,
                                input logic rwm, mis, be, sk);
        ob = '{v, w, s, a, wd, st, pc, pcb, alu, wr, rwm, mis, be, sk};
    endfunction

    function automatic m_w_reg_t wb(input logic rw, m2r, input logic [31:0] alu, rd,
                                    input logic [4:0] wr);
        wb = '{rw, m2r, alu, rd, wr};
    endfunction

    function automatic obs_t sample();
        sample = '{dbus.dreq_valid, dbus.dreq_write, dbus.dreq_strobe, dbus.dreq_addr,
                   dbus.dreq_wdata, mem_stall, pcsrc, pc_branch, aluoutM, write_regM,
                   reg_writeM, misalign, bus_err, bus_err_sticky};
    endfunction

    task automatic chk_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input m_w_reg_t exp);
        n_cmp++;
        if (m_w_reg !== exp) begin
            n_bad++;
            $display("FAIL %s: m_w_reg %h, expected %h", name, m_w_reg, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic run_vec(input int i);
        e_m_reg = vecs[i].em;
        @(posedge clk); #1;
        e_m_reg = '0;
        dbus.dresp_ready = vecs[i].ready;
        dbus.dresp_data  = vecs[i].rdata;
        @(negedge clk);
        chk_obs($sformatf("vec%0d_comb", i), vecs[i].exp_o);
        @(posedge clk); #1;
        dbus.dresp_ready = 1'b0;
        dbus.dresp_data  = 32'h0;
        chk_w($sformatf("vec%0d_w", i), vecs[i].exp_w);
    endtask

    initial begin
        logic [159:0] rnd;
        obs_t zero_o;
        zero_o = '0;

        vecs[0] = '{em(1,0,0,0,0, 32'h0, 32'h1234, 32'h0, 5), 1'b0, 32'h0,
                    ob(0,0,4'h0, 32'h1234, 32'h0, 0,0, 32'h0, 32'h1234, 5, 1,0,0,0),
                    wb(1,0, 32'h1234, 32'h0, 5)};
        vecs[1] = '{em(0,0,1,0,0, 32'h0, 32'h200, 32'hCAFEF00D, 0), 1'b1, 32'h55AA55AA,
                    ob(1,1,4'hF, 32'h200, 32'hCAFEF00D, 0,0, 32'h0, 32'h200, 0, 0,0,0,0),
                    wb(0,0, 32'h200, 32'h0, 0)};
        vecs[2] = '{em(1,1,0,0,0, 32'h0, 32'h300, 32'h0, 9), 1'b1, 32'h11223344,
                    ob(1,0,4'h0, 32'h300, 32'h0, 0,0, 32'h0, 32'h300, 9, 1,0,0,0),
                    wb(1,1, 32'h300, 32'h11223344, 9)};
        vecs[3] = '{em(1,1,0,0,0, 32'h0, 32'h102, 32'h0, 3), 1'b1, 32'hBAD0BAD0,
                    ob(0,0,4'h0, 32'h102, 32'h0, 0,0, 32'h0, 32'h102, 3, 1,1,0,0),
                    wb(0,1, 32'h102, 32'h0, 3)};
        vecs[4] = '{em(0,0,0,1,1, 32'h400, 32'h0, 32'h0, 0), 1'b0, 32'h0,
                    ob(0,0,4'h0, 32'h0, 32'h0, 0,1, 32'h400, 32'h0, 0, 0,0,0,0),
                    wb(0,0, 32'h0, 32'h0, 0)};
        vecs[5] = '{em(0,0,0,1,0, 32'h400, 32'h0, 32'h0, 0), 1'b0, 32'h0,
                    ob(0,0,4'h0, 32'h0, 32'h0, 0,0, 32'h400, 32'h0, 0, 0,0,0,0),
                    wb(0,0, 32'h0, 32'h0, 0)};
        vecs[6] = '{em(1,0,0,0,0, 32'h0, 32'hABCD, 32'h0, 12), 1'b1, 32'hFFFFFFFF,
                    ob(0,0,4'h0, 32'hABCD, 32'h0, 0,0, 32'h0, 32'hABCD, 12, 1,0,0,0),
                    wb(1,0, 32'hABCD, 32'h0, 12)};
        vecs[7] = '{em(0,0,1,0,0, 32'h0, 32'h203, 32'h12345678, 0), 1'b0, 32'h0,
                    ob(0,1,4'hF, 32'h203, 32'h12345678, 0,0, 32'h0, 32'h203, 0, 0,1,0,0),
                    wb(0,0, 32'h203, 32'h0, 0)};

        // Reset with random upstream traffic and a stray ready.
        resetn = 1'b0;
        dbus.dresp_ready = 1'b1;
        dbus.dresp_data  = 32'hFFFF_0000;
        for (int c = 0; c < 3; c++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            e_m_reg = e_m_reg_t'(rnd[$bits(e_m_reg_t)-1:0]);
            @(negedge clk);
            chk_obs($sformatf("reset_outs%0d", c), zero_o);
            chk_w($sformatf("reset_w%0d", c), '0);
        end
        resetn = 1'b1;
        dbus.dresp_ready = 1'b0;
        dbus.dresp_data  = 32'h0;
        e_m_reg = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Load with three wait cycles; the fourth-cycle ready lands on the limit.
        e_m_reg = em(1,1,0,1,1, 32'h800, 32'h100, 32'h0, 4);
        @(posedge clk); #1;
        e_m_reg = em(1,0,0,0,0, 32'h0, 32'h5555, 32'h0, 6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_obs($sformatf("wait_stall%0d", k),
                    ob(1,0,4'h0, 32'h100, 32'h0, 1,1, 32'h800, 32'h100, 4, 1,0,0,0));
            @(posedge clk); #1;
            chk_w($sformatf("wait_bubble%0d", k), '0);
        end
        dbus.dresp_ready = 1'b1;
        dbus.dresp_data  = 32'hDEADBEEF;
        @(negedge clk);
        chk_obs("wait_done", ob(1,0,4'h0, 32'h100, 32'h0, 0,1, 32'h800, 32'h100, 4, 1,0,0,0));
        @(posedge clk); #1;
        dbus.dresp_ready = 1'b0;
        dbus.dresp_data  = 32'h0;
        e_m_reg = '0;
        chk_w("wait_w", wb(1,1, 32'h100, 32'hDEADBEEF, 4));
        chk32("wait_next_in_m", aluoutM, 32'h5555);
        @(posedge clk); #1;
        chk_w("wait_next_w", wb(1,0, 32'h5555, 32'h0, 6));

        // Timeout: ready never comes.
        e_m_reg = em(1,1,0,0,0, 32'h0, 32'h180, 32'h0, 7);
        @(posedge clk); #1;
        e_m_reg = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_obs($sformatf("to_stall%0d", k),
                    ob(1,0,4'h0, 32'h180, 32'h0, 1,0, 32'h0, 32'h180, 7, 1,0,0,0));
            @(posedge clk); #1;
            chk_w($sformatf("to_bubble%0d", k), '0);
        end
        @(negedge clk);
        chk_obs("to_abort", ob(0,0,4'h0, 32'h180, 32'h0, 0,0, 32'h0, 32'h180, 7, 1,0,1,0));
        @(posedge clk); #1;
        chk_w("to_w", wb(0,1, 32'h180, 32'h0, 7));
        e_m_reg = em(1,1,0,0,0, 32'h0, 32'h104, 32'h0, 8);
        @(negedge clk);
        chk_obs("to_after", ob(0,0,4'h0, 32'h0, 32'h0, 0,0, 32'h0, 32'h0, 0, 0,0,0,1));
        @(posedge clk); #1;
        e_m_reg = '0;
        dbus.dresp_ready = 1'b1;
        dbus.dresp_data  = 32'h600DF00D;
        @(negedge clk);
        chk_obs("to_reload", ob(1,0,4'h0, 32'h104, 32'h0, 0,0, 32'h0, 32'h104, 8, 1,0,0,1));
        @(posedge clk); #1;
        dbus.dresp_ready = 1'b0;
        dbus.dresp_data  = 32'h0;
        chk_w("to_reload_w", wb(1,1, 32'h104, 32'h600DF00D, 8));

        // Reset in the middle of a waiting access; also clears the sticky error.
        e_m_reg = em(1,1,0,0,0, 32'h0, 32'h140, 32'h0, 2);
        @(posedge clk); #1;
        e_m_reg = '0;
        @(posedge clk); #1;
        chk32("mid_pre_stall", {31'h0, mem_stall}, 32'h1);
        resetn = 1'b0;
        #1;
        chk_obs("mid_reset_outs", zero_o);
        chk_w("mid_reset_w", '0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_obs("mid_after_outs", zero_o);
        chk_w("mid_after_w", '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
